// File: rtl/mult_ctrl_pkg.sv
// Shared definitions for the shift-add multiplier controller: controller state
// encoding and the default iteration counter width.
package mult_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctrl_state_e;

  localparam int MULT_CNT_W = 3;

endpackage

// File: rtl/seq_step_counter.sv
// Step counter that sequences multiplier iterations: runs limit+1 steps per
// operation, up or down, with stall, abort and a one-cycle done pulse.
module seq_step_counter
  import mult_ctrl_pkg::*;
#(
  parameter int CNT_W = MULT_CNT_W,
  parameter bit DOWN  = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_limit,
  input  logic             i_hold,
  input  logic             i_abort,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_busy,
  output logic             o_last,
  output logic             o_done
);

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lim_q, lim_d;
  logic [CNT_W-1:0] end_val;
  logic [CNT_W-1:0] load_val;

  assign end_val  = DOWN ? '0 : lim_q;
  assign load_val = DOWN ? i_limit : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lim_d   = lim_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (i_start) begin
          lim_d   = i_limit;
          cnt_d   = load_val;
          state_d = RUN;
        end
      end
      RUN: begin
        // The exit test precedes the step, so the count never wraps.
        if (i_abort) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (!i_hold) begin
          if (cnt_q == end_val) begin
            state_d = DONE;
          end else if (DOWN) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (i_start) begin
          lim_d   = i_limit;
          cnt_d   = load_val;
          state_d = RUN;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lim_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
    end
  end

  assign o_cnt  = cnt_q;
  assign o_busy = (state_q == RUN);
  assign o_done = (state_q == DONE);
  assign o_last = (state_q == RUN) && (cnt_q == end_val);

endmodule
